// File: rtl/multicycle_controller.sv
// Multicycle MIPS-subset control FSM with retired-instruction counter and sticky illegal flag.
// Define CTRL_JUMP_EN to enable the JUMP state (opcode 000010); otherwise j is illegal.
module multicycle_controller #(
  parameter int ALUOP_W = 2,
  parameter int CNT_W   = 16,
  parameter int MEM_HS  = 1
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic [5:0]         opcode,
  input  logic [5:0]         func,
  input  logic               mem_ready,
  output logic               pc_write,
  output logic               pc_write_cond,
  output logic               iord,
  output logic               mem_read,
  output logic               mem_write,
  output logic               ir_write,
  output logic               reg_dst,
  output logic               mem_to_reg,
  output logic               reg_write,
  output logic               alu_src_a,
  output logic [1:0]         alu_src_b,
  output logic [ALUOP_W-1:0] alu_op,
  output logic [1:0]         pc_source,
  output logic [3:0]         state,
  output logic               illegal,
  output logic [CNT_W-1:0]   instr_count
);

  // state | meaning
  // 0 FETCH | 1 DECODE | 2 MEM_ADDR | 3 MEM_RD | 4 MEM_WB | 5 MEM_WR
  // 6 R_EXEC | 7 R_WB | 8 BRANCH | 9 ADDI_EXEC | 10 ADDI_WB | 11 JUMP
  localparam logic [3:0] S_FETCH     = 4'd0;
  localparam logic [3:0] S_DECODE    = 4'd1;
  localparam logic [3:0] S_MEM_ADDR  = 4'd2;
  localparam logic [3:0] S_MEM_RD    = 4'd3;
  localparam logic [3:0] S_MEM_WB    = 4'd4;
  localparam logic [3:0] S_MEM_WR    = 4'd5;
  localparam logic [3:0] S_R_EXEC    = 4'd6;
  localparam logic [3:0] S_R_WB      = 4'd7;
  localparam logic [3:0] S_BRANCH    = 4'd8;
  localparam logic [3:0] S_ADDI_EXEC = 4'd9;
  localparam logic [3:0] S_ADDI_WB   = 4'd10;
`ifdef CTRL_JUMP_EN
  localparam logic [3:0] S_JUMP      = 4'd11;
  localparam logic [5:0] OP_J        = 6'b000010;
`endif

  localparam logic [5:0] OP_RTYPE = 6'b000000;
  localparam logic [5:0] OP_LW    = 6'b100011;
  localparam logic [5:0] OP_SW    = 6'b101011;
  localparam logic [5:0] OP_BEQ   = 6'b000100;
  localparam logic [5:0] OP_ADDI  = 6'b001000;

  logic [3:0]       r_state;
  logic             r_is_store;
  logic             r_illegal;
  logic [CNT_W-1:0] r_instr_count;

  logic [3:0] w_next;
  logic       w_ready;
  logic       w_func_ok;
  logic       w_set_illegal;
  logic       w_retire;

  logic       w_pc_write;
  logic       w_pc_write_cond;
  logic       w_iord;
  logic       w_mem_read;
  logic       w_mem_write;
  logic       w_ir_write;
  logic       w_reg_dst;
  logic       w_mem_to_reg;
  logic       w_reg_write;
  logic       w_alu_src_a;
  logic [1:0] w_alu_src_b;
  logic [1:0] w_alu_op;
  logic [1:0] w_pc_source;

  assign w_ready = (MEM_HS == 0) ? 1'b1 : mem_ready;

  assign w_func_ok = (func == 6'b100000) || (func == 6'b100010) ||
                     (func == 6'b100100) || (func == 6'b100101) ||
                     (func == 6'b101010);

  always_comb begin
    w_next        = S_FETCH;
    w_set_illegal = 1'b0;
    w_retire      = 1'b0;
    case (r_state)
      S_FETCH:  w_next = w_ready ? S_DECODE : S_FETCH;
      S_DECODE: begin
        case (opcode)
          OP_RTYPE: begin
            if (w_func_ok) w_next = S_R_EXEC;
            else           w_set_illegal = 1'b1;
          end
          OP_LW, OP_SW: w_next = S_MEM_ADDR;
          OP_BEQ:       w_next = S_BRANCH;
          OP_ADDI:      w_next = S_ADDI_EXEC;
`ifdef CTRL_JUMP_EN
          OP_J:         w_next = S_JUMP;
`endif
          default:      w_set_illegal = 1'b1;
        endcase
      end
      S_MEM_ADDR:  w_next = r_is_store ? S_MEM_WR : S_MEM_RD;
      S_MEM_RD:    w_next = w_ready ? S_MEM_WB : S_MEM_RD;
      S_MEM_WB:    w_retire = 1'b1;
      S_MEM_WR: begin
        w_next   = w_ready ? S_FETCH : S_MEM_WR;
        w_retire = w_ready;
      end
      S_R_EXEC:    w_next = S_R_WB;
      S_R_WB:      w_retire = 1'b1;
      S_BRANCH:    w_retire = 1'b1;
      S_ADDI_EXEC: w_next = S_ADDI_WB;
      S_ADDI_WB:   w_retire = 1'b1;
`ifdef CTRL_JUMP_EN
      S_JUMP:      w_retire = 1'b1;
`endif
      default:     w_next = S_FETCH;
    endcase
  end

  // The lw/sw choice is captured at DECODE so MEM_ADDR does not depend on opcode staying valid.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state       <= S_FETCH;
      r_is_store    <= 1'b0;
      r_illegal     <= 1'b0;
      r_instr_count <= '0;
    end else begin
      r_state <= w_next;
      if (r_state == S_DECODE) r_is_store <= (opcode == OP_SW);
      if (w_set_illegal) r_illegal <= 1'b1;
      if (w_retire) r_instr_count <= r_instr_count + CNT_W'(1);
    end
  end

  always_comb begin
    w_pc_write      = 1'b0;
    w_pc_write_cond = 1'b0;
    w_iord          = 1'b0;
    w_mem_read      = 1'b0;
    w_mem_write     = 1'b0;
    w_ir_write      = 1'b0;
    w_reg_dst       = 1'b0;
    w_mem_to_reg    = 1'b0;
    w_reg_write     = 1'b0;
    w_alu_src_a     = 1'b0;
    w_alu_src_b     = 2'b00;
    w_alu_op        = 2'b00;
    w_pc_source     = 2'b00;
    case (r_state)
      S_FETCH: begin
        w_mem_read  = 1'b1;
        w_alu_src_b = 2'b01;
        w_ir_write  = w_ready;
        w_pc_write  = w_ready;
      end
      S_DECODE:   w_alu_src_b = 2'b11;
      S_MEM_ADDR: begin
        w_alu_src_a = 1'b1;
        w_alu_src_b = 2'b10;
      end
      S_MEM_RD: begin
        w_iord     = 1'b1;
        w_mem_read = 1'b1;
      end
      S_MEM_WB: begin
        w_reg_write  = 1'b1;
        w_mem_to_reg = 1'b1;
      end
      S_MEM_WR: begin
        w_iord      = 1'b1;
        w_mem_write = 1'b1;
      end
      S_R_EXEC: begin
        w_alu_src_a = 1'b1;
        w_alu_op    = 2'b10;
      end
      S_R_WB: begin
        w_reg_write = 1'b1;
        w_reg_dst   = 1'b1;
      end
      S_BRANCH: begin
        w_alu_src_a     = 1'b1;
        w_alu_op        = 2'b01;
        w_pc_write_cond = 1'b1;
        w_pc_source     = 2'b01;
      end
      S_ADDI_EXEC: begin
        w_alu_src_a = 1'b1;
        w_alu_src_b = 2'b10;
      end
      S_ADDI_WB: w_reg_write = 1'b1;
`ifdef CTRL_JUMP_EN
      S_JUMP: begin
        w_pc_write  = 1'b1;
        w_pc_source = 2'b10;
      end
`endif
      default: ;
    endcase
  end

  // Strobes are masked while reset is held, even though FETCH would otherwise read memory.
  assign pc_write      = rst_n & w_pc_write;
  assign pc_write_cond = rst_n & w_pc_write_cond;
  assign iord          = rst_n & w_iord;
  assign mem_read      = rst_n & w_mem_read;
  assign mem_write     = rst_n & w_mem_write;
  assign ir_write      = rst_n & w_ir_write;
  assign reg_dst       = rst_n & w_reg_dst;
  assign mem_to_reg    = rst_n & w_mem_to_reg;
  assign reg_write     = rst_n & w_reg_write;
  assign alu_src_a     = rst_n & w_alu_src_a;
  assign alu_src_b     = rst_n ? w_alu_src_b : 2'b00;
  assign pc_source     = rst_n ? w_pc_source : 2'b00;

  always_comb begin
    alu_op = '0;
    if (rst_n) alu_op[1:0] = w_alu_op;
  end

  assign state       = r_state;
  assign illegal     = r_illegal;
  assign instr_count = r_instr_count;

endmodule

// File: tb/tb_multicycle_controller.sv
// Randomized and directed bench for multicycle_controller against an instruction-path model.
module tb_multicycle_controller;

  logic       clk;
  logic       rst_n;
  logic [5:0] opcode;
  logic [5:0] func;
  logic       mem_ready;

  logic        pc_write, pc_write_cond, iord, mem_read, mem_write, ir_write;
  logic        reg_dst, mem_to_reg, reg_write, alu_src_a;
  logic [1:0]  alu_src_b, alu_op, pc_source;
  logic [3:0]  st;
  logic        ill;
  logic [15:0] cnt;

  logic        s_pc_write, s_pc_write_cond, s_iord, s_mem_read, s_mem_write, s_ir_write;
  logic        s_reg_dst, s_mem_to_reg, s_reg_write, s_alu_src_a;
  logic [1:0]  s_alu_src_b, s_alu_op, s_pc_source;
  logic [3:0]  s_st;
  logic        s_ill;
  logic [1:0]  s_cnt;

  logic [15:0] bundle;

  int n_vec = 0;
  int n_err = 0;

  int          m_state;
  int unsigned m_count;
  bit          m_illegal;
  int          m_path[$];

  int          obs[$];
  logic [15:0] obs_b[$];

  multicycle_controller #(.ALUOP_W(2), .CNT_W(16), .MEM_HS(1)) u_dut (
    .clk(clk), .rst_n(rst_n), .opcode(opcode), .func(func), .mem_ready(mem_ready),
    .pc_write(pc_write), .pc_write_cond(pc_write_cond), .iord(iord), .mem_read(mem_read),
    .mem_write(mem_write), .ir_write(ir_write), .reg_dst(reg_dst), .mem_to_reg(mem_to_reg),
    .reg_write(reg_write), .alu_src_a(alu_src_a), .alu_src_b(alu_src_b), .alu_op(alu_op),
    .pc_source(pc_source), .state(st), .illegal(ill), .instr_count(cnt)
  );

  multicycle_controller #(.ALUOP_W(2), .CNT_W(2), .MEM_HS(1)) u_small (
    .clk(clk), .rst_n(rst_n), .opcode(opcode), .func(func), .mem_ready(mem_ready),
    .pc_write(s_pc_write), .pc_write_cond(s_pc_write_cond), .iord(s_iord),
    .mem_read(s_mem_read), .mem_write(s_mem_write), .ir_write(s_ir_write),
    .reg_dst(s_reg_dst), .mem_to_reg(s_mem_to_reg), .reg_write(s_reg_write),
    .alu_src_a(s_alu_src_a), .alu_src_b(s_alu_src_b), .alu_op(s_alu_op),
    .pc_source(s_pc_source), .state(s_st), .illegal(s_ill), .instr_count(s_cnt)
  );

  // [15]pcw [14]pcwc [13]iord [12]mrd [11]mwr [10]irw [9]rdst [8]m2r [7]rw [6]asa [5:4]asb [3:2]aop [1:0]psrc
  assign bundle = {pc_write, pc_write_cond, iord, mem_read, mem_write, ir_write,
                   reg_dst, mem_to_reg, reg_write, alu_src_a, alu_src_b, alu_op, pc_source};

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string name, input int act, input int exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  function automatic logic [15:0] exp_bundle(input int s, input bit mr);
    logic [15:0] b;
    b = '0;
    case (s)
      0:  begin b[12] = 1'b1; b[5:4] = 2'b01; b[10] = mr; b[15] = mr; end
      1:  b[5:4] = 2'b11;
      2:  begin b[6] = 1'b1; b[5:4] = 2'b10; end
      3:  begin b[13] = 1'b1; b[12] = 1'b1; end
      4:  begin b[7] = 1'b1; b[8] = 1'b1; end
      5:  begin b[13] = 1'b1; b[11] = 1'b1; end
      6:  begin b[6] = 1'b1; b[3:2] = 2'b10; end
      7:  begin b[7] = 1'b1; b[9] = 1'b1; end
      8:  begin b[6] = 1'b1; b[3:2] = 2'b01; b[14] = 1'b1; b[1:0] = 2'b01; end
      9:  begin b[6] = 1'b1; b[5:4] = 2'b10; end
      10: b[7] = 1'b1;
      11: begin b[15] = 1'b1; b[1:0] = 2'b10; end
      default: b = '0;
    endcase
    return b;
  endfunction

  function automatic bit func_ok(input logic [5:0] f);
    return f == 6'b100000 || f == 6'b100010 || f == 6'b100100 ||
           f == 6'b100101 || f == 6'b101010;
  endfunction

  // States visited after FETCH; a lone DECODE means the instruction is rejected.
  task automatic plan(input logic [5:0] op, input logic [5:0] fn);
    m_path.delete();
    m_path.push_back(1);
    case (op)
      6'b000000: if (func_ok(fn)) begin m_path.push_back(6); m_path.push_back(7); end
      6'b100011: begin m_path.push_back(2); m_path.push_back(3); m_path.push_back(4); end
      6'b101011: begin m_path.push_back(2); m_path.push_back(5); end
      6'b000100: m_path.push_back(8);
      6'b001000: begin m_path.push_back(9); m_path.push_back(10); end
`ifdef CTRL_JUMP_EN
      6'b000010: m_path.push_back(11);
`endif
      default: ;
    endcase
  endtask

  task automatic model_reset();
    m_state = 0;
    m_count = 0;
    m_illegal = 0;
    m_path.delete();
  endtask

  task automatic model_step(input bit mr);
    if ((m_state == 0 || m_state == 3 || m_state == 5) && !mr) return;
    if (m_state == 0) plan(opcode, func);
    if (m_path.size() == 0) begin
      if (m_state == 1) m_illegal = 1;
      else m_count++;
      m_state = 0;
    end else begin
      m_state = m_path.pop_front();
    end
  endtask

  task automatic check_all();
    logic [15:0] eb;
    eb = rst_n ? exp_bundle(m_state, mem_ready) : 16'h0000;
    chk("state", int'(st), m_state);
    chk("small_state", int'(s_st), m_state);
    chk("illegal", int'(ill), int'(m_illegal));
    chk("instr_count", int'(cnt), int'(m_count % 65536));
    chk("small_instr_count", int'(s_cnt), int'(m_count % 4));
    chk("strobes", int'(bundle), int'(eb));
  endtask

  task automatic cyc(input bit mr);
    mem_ready = mr;
    #1;
    check_all();
    obs.push_back(int'(st));
    obs_b.push_back(bundle);
    @(posedge clk);
    if (rst_n) model_step(mr);
    @(negedge clk);
  endtask

  task automatic chk_seq(input string name, input int e[$]);
    chk({name, "_len"}, obs.size(), e.size());
    for (int k = 0; k < e.size() && k < obs.size(); k++) chk(name, obs[k], e[k]);
  endtask

  task automatic do_reset();
    #2 rst_n = 1'b0;
    model_reset();
    #1;
    chk("rst_state", int'(st), 0);
    chk("rst_count", int'(cnt), 0);
    chk("rst_small_count", int'(s_cnt), 0);
    chk("rst_illegal", int'(ill), 0);
    chk("rst_strobes", int'(bundle), 0);
    @(posedge clk);
    @(negedge clk);
    #1 check_all();
    rst_n = 1'b1;
  endtask

  task automatic run_instr(input logic [5:0] op, input logic [5:0] fn);
    opcode = op;
    func = fn;
    obs.delete();
    obs_b.delete();
    cyc(1'b1);
    for (int k = 0; k < 20 && m_state != 0; k++) cyc(1'b1);
    chk("run_bound", m_state, 0);
    #1 chk("run_end_state", int'(st), 0);
  endtask

  initial begin
    int e[$];
    logic [15:0] b;
    rst_n = 1'b0;
    opcode = 6'd0;
    func = 6'd0;
    mem_ready = 1'b1;
    model_reset();
    @(negedge clk);
    #1 check_all();
    chk("por_state", int'(st), 0);
    chk("por_count", int'(cnt), 0);
    chk("por_mem_read_forced", int'(mem_read), 0);
    @(negedge clk);
    rst_n = 1'b1;

    // R-type add
    run_instr(6'b000000, 6'b100000);
    e = {0, 1, 6, 7};
    chk_seq("rtype_seq", e);
    b = obs_b[3];
    chk("rwb_reg_dst", int'(b[9]), 1);
    chk("rwb_reg_write", int'(b[7]), 1);
    chk("rtype_count", int'(cnt), 1);

    // lw with three not-ready cycles in MEM_RD
    opcode = 6'b100011;
    obs.delete();
    obs_b.delete();
    cyc(1); cyc(1); cyc(1);
    cyc(0); cyc(0); cyc(0);
    cyc(1); cyc(1);
    e = {0, 1, 2, 3, 3, 3, 3, 4};
    chk_seq("lw_seq", e);
    for (int k = 3; k < 7; k++) begin
      b = obs_b[k];
      chk("memrd_mem_read", int'(b[12]), 1);
      chk("memrd_iord", int'(b[13]), 1);
    end
    b = obs_b[7];
    chk("memwb_mem_to_reg", int'(b[8]), 1);
    chk("lw_count", int'(cnt), 2);

    // sw then beq from a fresh reset
    do_reset();
    run_instr(6'b101011, 6'd0);
    e = {0, 1, 2, 5};
    chk_seq("sw_seq", e);
    b = obs_b[3];
    chk("memwr_mem_write", int'(b[11]), 1);
    run_instr(6'b000100, 6'd0);
    e = {0, 1, 8};
    chk_seq("beq_seq", e);
    b = obs_b[2];
    chk("branch_pcwc", int'(b[14]), 1);
    chk("branch_alu_op", int'(b[3:2]), 1);
    chk("branch_pc_source", int'(b[1:0]), 1);
    chk("sw_beq_count", int'(cnt), 2);

    // illegal R-type func, flag stays sticky
    run_instr(6'b000000, 6'b000111);
    e = {0, 1};
    chk_seq("illegal_seq", e);
    chk("illegal_set", int'(ill), 1);
    chk("illegal_count", int'(cnt), 2);
    run_instr(6'b001000, 6'd0);
    e = {0, 1, 9, 10};
    chk_seq("addi_seq", e);
    chk("illegal_sticky", int'(ill), 1);
    chk("addi_count", int'(cnt), 3);

    // jump
    do_reset();
    run_instr(6'b000010, 6'd0);
`ifdef CTRL_JUMP_EN
    e = {0, 1, 11};
    chk_seq("jump_seq", e);
    b = obs_b[2];
    chk("jump_pc_source", int'(b[1:0]), 2);
    chk("jump_pc_write", int'(b[15]), 1);
    chk("jump_count", int'(cnt), 1);
    chk("jump_illegal", int'(ill), 0);
`else
    e = {0, 1};
    chk_seq("jump_seq", e);
    chk("jump_count", int'(cnt), 0);
    chk("jump_illegal", int'(ill), 1);
`endif

    // 2-bit counter wrap
    do_reset();
    run_instr(6'b000000, 6'b100010); chk("wrap1", int'(s_cnt), 1);
    run_instr(6'b000100, 6'd0);      chk("wrap2", int'(s_cnt), 2);
    run_instr(6'b001000, 6'd0);      chk("wrap3", int'(s_cnt), 3);
    run_instr(6'b101011, 6'd0);      chk("wrap0", int'(s_cnt), 0);
    run_instr(6'b000000, 6'b101010); chk("wrap1b", int'(s_cnt), 1);
    chk("wide_count5", int'(cnt), 5);

    // reset in R_EXEC
    opcode = 6'b000000;
    func = 6'b100000;
    cyc(1); cyc(1);
    #1 chk("in_r_exec", int'(st), 6);
    do_reset();
    run_instr(6'b000000, 6'b100000);
    e = {0, 1, 6, 7};
    chk_seq("post_reset_seq", e);
    chk("post_reset_count", int'(cnt), 1);

    // random traffic
    for (int i = 0; i < 3000; i++) begin
      obs.delete();
      obs_b.delete();
      if (m_state == 0) begin
        case ($urandom_range(0, 7))
          0, 7: begin
            opcode = 6'b000000;
            if ($urandom_range(0, 4) == 0) func = 6'($urandom);
            else case ($urandom_range(0, 4))
              0: func = 6'b100000;
              1: func = 6'b100010;
              2: func = 6'b100100;
              3: func = 6'b100101;
              default: func = 6'b101010;
            endcase
          end
          1: opcode = 6'b100011;
          2: opcode = 6'b101011;
          3: opcode = 6'b000100;
          4: opcode = 6'b001000;
          5: opcode = 6'b000010;
          default: begin opcode = 6'($urandom); func = 6'($urandom); end
        endcase
      end
      if ($urandom_range(0, 199) == 0) do_reset();
      else cyc($urandom_range(0, 3) != 0);
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
